// File: rtl/ifu_bp_upd_ctl_pkg.sv
// Shared types and sizes for the branch-predictor update path.
package ifu_bp_upd_ctl_pkg;

  localparam int unsigned BHT_AW       = 8;
  localparam int unsigned WAYS_W       = 1;
  localparam int unsigned BP_UPD_DEPTH = 4;

  typedef struct packed {
    logic              misp;
    logic              ataken;
    logic [1:0]        hist;
    logic              tgt_err;
    logic [WAYS_W-1:0] way;
    logic [BHT_AW-1:0] index;
  } bp_upd_pkt_t;

  localparam int unsigned BP_UPD_W = $bits(bp_upd_pkt_t);

endpackage

// File: rtl/ifu_bp_upd_fifo.sv
// Generic FIFO with wrap-bit pointers; a push into a full FIFO with no pop drops the oldest entry.
// i_ovr rewrites the newest entry in place without moving any pointer.
module ifu_bp_upd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_ovr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_head,
  output logic [WIDTH-1:0] o_tail,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_one,
  output logic             o_drop
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      r_rd;
  logic [AW:0]      r_wr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    w_wr_idx;
  logic [AW-1:0]    w_tail_idx;

  assign w_wr_idx   = r_wr[AW-1:0];
  assign w_tail_idx = r_wr[AW-1:0] - AW'(1);

  assign o_empty = (r_rd == r_wr);
  assign o_full  = (r_rd[AW] != r_wr[AW]) && (r_rd[AW-1:0] == r_wr[AW-1:0]);
  assign o_one   = ((r_wr - r_rd) == (AW+1)'(1));
  assign o_drop  = i_push & o_full & ~i_pop;
  assign o_head  = r_mem[r_rd[AW-1:0]];
  assign o_tail  = r_mem[w_tail_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd <= '0;
      r_wr <= '0;
    end else begin
      if (i_pop || o_drop) r_rd <= r_rd + (AW+1)'(1);
      if (i_push)          r_wr <= r_wr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: outputs are qualified by o_empty downstream.
  always_ff @(posedge clk) begin
    if (i_push)     r_mem[w_wr_idx]   <= i_wdata;
    else if (i_ovr) r_mem[w_tail_idx] <= i_wdata;
  end

endmodule

// File: rtl/ifu_bp_upd_ctl.sv
// Buffers resolved-branch updates and retires them to the BHT write / BTB invalidate ports.
// Optional macro BP_UPD_MERGE_EN: merge a push into a matching newest entry instead of allocating.
module ifu_bp_upd_ctl
  import ifu_bp_upd_ctl_pkg::*;
#(
  parameter int unsigned DEPTH = BP_UPD_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              upd_valid,
  input  bp_upd_pkt_t       upd_pkt,
  input  logic              upd_kill,
  input  logic              bht_wr_stall,
  output logic              bht_wr_en,
  output logic [BHT_AW-1:0] bht_wr_addr,
  output logic [WAYS_W-1:0] bht_wr_way,
  output logic [1:0]        bht_wr_data,
  output logic              btb_inv_en,
  output logic [BHT_AW-1:0] btb_inv_addr,
  output logic              upd_busy,
  output logic              upd_drop
);

  logic        w_push;
  logic        w_pop;
  logic        w_merge;
  logic        w_empty;
  logic        w_full;
  logic        w_one;
  bp_upd_pkt_t w_head;
  bp_upd_pkt_t w_tail;
  bp_upd_pkt_t w_wdata;

  assign w_push = upd_valid & ~upd_kill;
  assign w_pop  = ~w_empty & ~bht_wr_stall;

`ifdef BP_UPD_MERGE_EN
  // The newest entry is only mergeable if it is not leaving the FIFO this cycle.
  assign w_merge = w_push & ~w_empty & ~(w_pop & w_one) &
                   (w_tail.index == upd_pkt.index) & (w_tail.way == upd_pkt.way);

  always_comb begin
    w_wdata         = upd_pkt;
    w_wdata.tgt_err = upd_pkt.tgt_err | (w_merge & w_tail.tgt_err);
  end

  logic w_unused;
  assign w_unused = ^{w_full, w_head.misp, w_head.ataken};
`else
  assign w_merge = 1'b0;
  assign w_wdata = upd_pkt;

  logic w_unused;
  assign w_unused = ^{w_full, w_one, w_tail, w_head.misp, w_head.ataken};
`endif

  ifu_bp_upd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (BP_UPD_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push & ~w_merge),
    .i_pop   (w_pop),
    .i_ovr   (w_merge),
    .i_wdata (w_wdata),
    .o_head  (w_head),
    .o_tail  (w_tail),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_one   (w_one),
    .o_drop  (upd_drop)
  );

  always_comb begin
    bht_wr_en    = w_pop;
    btb_inv_en   = w_pop & w_head.tgt_err;
    upd_busy     = ~w_empty;
    bht_wr_addr  = '0;
    bht_wr_way   = '0;
    bht_wr_data  = '0;
    btb_inv_addr = '0;
    if (!w_empty) begin
      bht_wr_addr  = w_head.index;
      bht_wr_way   = w_head.way;
      bht_wr_data  = w_head.hist;
      btb_inv_addr = w_head.index;
    end
  end

endmodule
